// File: rtl/bram_arbiter_pkg.sv
// Common definitions for the BRAM arbiter and its grant logic.
package bram_arbiter_pkg;

   localparam int DEFAULT_NB_USERS = 2;

   // User-id width, clamped to one bit so a single-user build still has a legal vector.
   function automatic int id_width(input int nb_users);
      return (nb_users > 1) ? $clog2(nb_users) : 1;
   endfunction

endpackage

// File: rtl/pcie_consts.sv
// Shared PCIe-side BRAM constants used as defaults by the BRAM datapath blocks.
package pcie_consts;

   localparam int BRAM_ADDR_WIDTH = 10;
   localparam int BRAM_DATA_WIDTH = 512;
   localparam int BRAM_RD_LATENCY = 2;

endpackage

// File: rtl/rr_arbiter.sv
// Grant logic: one-hot grant from requests. Round-robin when BRAM_ARBITER_ROUND_ROBIN_EN
// is defined, otherwise fixed priority with the lowest index winning.
module rr_arbiter
   import bram_arbiter_pkg::*;
#(
   parameter int NB_USERS = DEFAULT_NB_USERS,
   parameter int ID_WIDTH = id_width(NB_USERS)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NB_USERS-1:0] req,
   output logic [NB_USERS-1:0] grant,
   output logic [ID_WIDTH-1:0] grant_id,
   output logic                grant_vld
);

`ifdef BRAM_ARBITER_ROUND_ROBIN_EN
   logic [ID_WIDTH-1:0] ptr;

   // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch appears.
   always_comb begin
      int   idx;
      logic found;
      grant    = '0;
      grant_id = '0;
      found    = 1'b0;
      for (int off = 0; off < NB_USERS; off++) begin
         idx = (int'(ptr) + off) % NB_USERS;
         if (!found && req[idx]) begin
            found       = 1'b1;
            grant[idx]  = 1'b1;
            grant_id    = ID_WIDTH'(idx);
         end
      end
      if (rst) begin
         grant = '0;
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr <= '0;
      end else if (|grant) begin
         ptr <= ID_WIDTH'((int'(grant_id) + 1) % NB_USERS);
      end
   end
`else
   logic unused_clk;
   assign unused_clk = clk;

   always_comb begin
      grant    = '0;
      grant_id = '0;
      // Scanning downwards lets the lowest requesting index overwrite any higher one.
      for (int i = NB_USERS - 1; i >= 0; i--) begin
         if (req[i]) begin
            grant    = '0;
            grant[i] = 1'b1;
            grant_id = ID_WIDTH'(i);
         end
      end
      if (rst) begin
         grant = '0;
      end
   end
`endif

   assign grant_vld = |grant;

endmodule

// File: rtl/bram_arbiter.sv
// Multiplexes NB_USERS request ports onto one BRAM port and routes read data back by user id.
// Grant policy is selected by BRAM_ARBITER_ROUND_ROBIN_EN (undefined: fixed priority).
module bram_arbiter
   import pcie_consts::*;
   import bram_arbiter_pkg::*;
#(
   parameter int NB_USERS   = DEFAULT_NB_USERS,
   parameter int ADDR_WIDTH = BRAM_ADDR_WIDTH,
   parameter int DATA_WIDTH = BRAM_DATA_WIDTH,
   parameter int RD_LATENCY = BRAM_RD_LATENCY
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic [NB_USERS-1:0][ADDR_WIDTH-1:0] in_addr,
   input  logic [NB_USERS-1:0][DATA_WIDTH-1:0] in_wr_data,
   input  logic [NB_USERS-1:0]                 in_rd_en,
   input  logic [NB_USERS-1:0]                 in_wr_en,
   output logic [NB_USERS-1:0]                 in_ready,
   output logic [NB_USERS-1:0][DATA_WIDTH-1:0] in_rd_data,
   output logic [NB_USERS-1:0]                 in_rd_valid,
   output logic [ADDR_WIDTH-1:0]               out_addr,
   output logic [DATA_WIDTH-1:0]               out_wr_data,
   output logic                                out_rd_en,
   output logic                                out_wr_en,
   input  logic [DATA_WIDTH-1:0]               out_rd_data
);

   localparam int ID_WIDTH = id_width(NB_USERS);
   localparam int DEPTH    = RD_LATENCY + 1;

   logic [NB_USERS-1:0]            req;
   logic [ID_WIDTH-1:0]            gnt_id;
   logic                           gnt_vld;
   logic                           acc_rd;
   logic                           acc_wr;
   logic [DEPTH-1:0]               pipe_vld;
   logic [DEPTH-1:0][ID_WIDTH-1:0] pipe_id;

   assign req = in_rd_en | in_wr_en;

   rr_arbiter #(
      .NB_USERS (NB_USERS),
      .ID_WIDTH (ID_WIDTH)
   ) u_arb (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .grant     (in_ready),
      .grant_id  (gnt_id),
      .grant_vld (gnt_vld)
   );

   assign acc_rd = gnt_vld & in_rd_en[gnt_id];
   assign acc_wr = gnt_vld & in_wr_en[gnt_id];

   // Address and write data only move on an accepted request, so idle cycles keep the last access visible.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_rd_en   <= 1'b0;
         out_wr_en   <= 1'b0;
         out_addr    <= '0;
         out_wr_data <= '0;
      end else begin
         out_rd_en <= acc_rd;
         out_wr_en <= acc_wr;
         if (gnt_vld) begin
            out_addr    <= in_addr[gnt_id];
            out_wr_data <= in_wr_data[gnt_id];
         end
      end
   end

   // Stage 0 lines up with out_rd_en; stage RD_LATENCY lines up with valid BRAM read data.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pipe_vld <= '0;
         pipe_id  <= '0;
      end else begin
         pipe_vld <= {pipe_vld[DEPTH-2:0], acc_rd};
         pipe_id  <= {pipe_id[DEPTH-2:0], gnt_id};
      end
   end

   // NOTE: the per-user read-data registers are plain flops, not a RAM, so clearing them on reset is legal and cheap.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         in_rd_valid <= '0;
         in_rd_data  <= '0;
      end else begin
         in_rd_valid <= '0;
         if (pipe_vld[DEPTH-1]) begin
            in_rd_valid[pipe_id[DEPTH-1]] <= 1'b1;
            in_rd_data[pipe_id[DEPTH-1]]  <= out_rd_data;
         end
      end
   end

endmodule

// File: tb/tb_bram_arbiter.sv
// Self-checking bench for bram_arbiter: transaction-level model plus a behavioural read-first BRAM.
`timescale 1ns/1ps
module tb_bram_arbiter;

   localparam int N  = 3;
   localparam int AW = 10;
   localparam int DW = 32;
   localparam int L  = 2;

   logic                 clk = 1'b0;
   logic                 rst;
   logic [N-1:0][AW-1:0] in_addr;
   logic [N-1:0][DW-1:0] in_wr_data;
   logic [N-1:0]         in_rd_en;
   logic [N-1:0]         in_wr_en;
   logic [N-1:0]         in_ready;
   logic [N-1:0][DW-1:0] in_rd_data;
   logic [N-1:0]         in_rd_valid;
   logic [AW-1:0]        out_addr;
   logic [DW-1:0]        out_wr_data;
   logic                 out_rd_en;
   logic                 out_wr_en;
   logic [DW-1:0]        out_rd_data;

   always #5 clk = ~clk;

   bram_arbiter #(
      .NB_USERS   (N),
      .ADDR_WIDTH (AW),
      .DATA_WIDTH (DW),
      .RD_LATENCY (L)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .in_addr     (in_addr),
      .in_wr_data  (in_wr_data),
      .in_rd_en    (in_rd_en),
      .in_wr_en    (in_wr_en),
      .in_ready    (in_ready),
      .in_rd_data  (in_rd_data),
      .in_rd_valid (in_rd_valid),
      .out_addr    (out_addr),
      .out_wr_data (out_wr_data),
      .out_rd_en   (out_rd_en),
      .out_wr_en   (out_wr_en),
      .out_rd_data (out_rd_data)
   );

   // Behavioural BRAM: read-first, data appears L cycles after out_rd_en.
   logic [DW-1:0] bram    [1<<AW];
   logic [DW-1:0] rd_pipe [L];
   always @(posedge clk) begin
      if (out_wr_en) bram[out_addr] <= out_wr_data;
      if (out_rd_en) rd_pipe[0] <= bram[out_addr];
      for (int i = 1; i < L; i++) rd_pipe[i] <= rd_pipe[i-1];
   end
   assign out_rd_data = rd_pipe[L-1];

   typedef struct {
      int            due;
      int            user;
      logic [DW-1:0] data;
   } resp_t;

   int            checks = 0;
   int            errors = 0;
   int            cyc    = 0;
   int            acc_user;
   int            m_ptr;
   resp_t         m_resp [$];
   logic [DW-1:0] m_mem [16];
   logic [DW-1:0] m_last_rd [N];
   logic          m_prev_rd, m_prev_wr;
   logic [AW-1:0] m_prev_addr;
   logic [DW-1:0] m_prev_data;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic int exp_grant(input logic [N-1:0] req);
`ifdef BRAM_ARBITER_ROUND_ROBIN_EN
      for (int off = 0; off < N; off++)
         if (req[(m_ptr + off) % N]) return (m_ptr + off) % N;
`else
      for (int u = 0; u < N; u++)
         if (req[u]) return u;
`endif
      return -1;
   endfunction

   task automatic model_reset();
      m_resp.delete();
      m_ptr       = 0;
      m_prev_rd   = 1'b0;
      m_prev_wr   = 1'b0;
      m_prev_addr = '0;
      m_prev_data = '0;
      for (int u = 0; u < N; u++) m_last_rd[u] = '0;
   endtask

   task automatic set_req(input int u, input logic rd, input logic wr, input int a, input logic [DW-1:0] d);
      in_rd_en[u]   = rd;
      in_wr_en[u]   = wr;
      in_addr[u]    = AW'(a);
      in_wr_data[u] = d;
   endtask

   task automatic clr_req(input int u);
      in_rd_en[u] = 1'b0;
      in_wr_en[u] = 1'b0;
   endtask

   // One clock cycle: compare DUT against the model at the falling edge, then apply the acceptance.
   task automatic do_cycle();
      logic [N-1:0] req, exp_ready, exp_rv;
      int g;
      @(negedge clk);
      req       = in_rd_en | in_wr_en;
      g         = exp_grant(req);
      exp_ready = '0;
      if (g >= 0) exp_ready[g] = 1'b1;
      check("in_ready", 64'(in_ready), 64'(exp_ready));
      check("out_rd_en", 64'(out_rd_en), 64'(m_prev_rd));
      check("out_wr_en", 64'(out_wr_en), 64'(m_prev_wr));
      check("out_addr", 64'(out_addr), 64'(m_prev_addr));
      check("out_wr_data", 64'(out_wr_data), 64'(m_prev_data));
      exp_rv = '0;
      for (int k = m_resp.size() - 1; k >= 0; k--) begin
         if (m_resp[k].due == cyc) begin
            exp_rv[m_resp[k].user]    = 1'b1;
            m_last_rd[m_resp[k].user] = m_resp[k].data;
            m_resp.delete(k);
         end
      end
      check("in_rd_valid", 64'(in_rd_valid), 64'(exp_rv));
      for (int u = 0; u < N; u++)
         check($sformatf("in_rd_data[%0d]", u), 64'(in_rd_data[u]), 64'(m_last_rd[u]));
      acc_user  = g;
      m_prev_rd = 1'b0;
      m_prev_wr = 1'b0;
      if (g >= 0) begin
         m_prev_rd   = in_rd_en[g];
         m_prev_wr   = in_wr_en[g];
         m_prev_addr = in_addr[g];
         m_prev_data = in_wr_data[g];
         if (in_rd_en[g]) m_resp.push_back('{cyc + L + 2, g, m_mem[int'(in_addr[g]) % 16]});
         if (in_wr_en[g]) m_mem[int'(in_addr[g]) % 16] = in_wr_data[g];
         m_ptr = (g + 1) % N;
      end
      @(posedge clk);
      cyc++;
      #1;
   endtask

   task automatic drain();
      for (int k = 0; k < 2 * N && (in_rd_en | in_wr_en) != '0; k++) begin
         do_cycle();
         if (acc_user >= 0) clr_req(acc_user);
      end
      repeat (L + 3) do_cycle();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // Reset with requests pending: everything must read as zero.
      rst        = 1'b1;
      in_addr    = '0;
      in_wr_data = '0;
      in_rd_en   = '1;
      in_wr_en   = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_in_ready", 64'(in_ready), 64'(0));
      check("rst_in_rd_valid", 64'(in_rd_valid), 64'(0));
      check("rst_out_en", 64'({out_rd_en, out_wr_en}), 64'(0));
      check("rst_out_addr", 64'(out_addr), 64'(0));
      check("rst_in_rd_data0", 64'(in_rd_data[0]), 64'(0));
      in_rd_en = '0;
      model_reset();
      rst = 1'b0;

      // Fill addresses 0..15 one user at a time.
      for (int a = 0; a < 16; a++) begin
         set_req(a % N, 1'b0, 1'b1, a, $urandom);
         do_cycle();
         clr_req(a % N);
      end
      do_cycle();
      for (int a = 0; a < 16; a++)
         check($sformatf("fill_bram[%0d]", a), 64'(bram[a]), 64'(m_mem[a]));

      // Users 0 and 1 hold writes continuously.
      set_req(0, 1'b0, 1'b1, $urandom_range(0, 15), $urandom);
      set_req(1, 1'b0, 1'b1, $urandom_range(0, 15), $urandom);
      repeat (8) begin
         do_cycle();
         if (acc_user >= 0) set_req(acc_user, 1'b0, 1'b1, $urandom_range(0, 15), $urandom);
      end
      drain();
      for (int a = 0; a < 16; a++)
         check($sformatf("wr_bram[%0d]", a), 64'(bram[a]), 64'(m_mem[a]));

      // Known value at 0x5, then user 1 reads it.
      set_req(0, 1'b0, 1'b1, 5, 32'hAB);
      do_cycle();
      clr_req(0);
      set_req(1, 1'b1, 1'b0, 5, '0);
      do_cycle();
      clr_req(1);
      repeat (L + 3) do_cycle();
      check("rd_0x5_data", 64'(in_rd_data[1]), 64'hAB);

      // Back-to-back reads u0@1, u1@2, u0@3.
      set_req(0, 1'b1, 1'b0, 1, '0);
      do_cycle();
      clr_req(0);
      set_req(1, 1'b1, 1'b0, 2, '0);
      do_cycle();
      clr_req(1);
      set_req(0, 1'b1, 1'b0, 3, '0);
      do_cycle();
      clr_req(0);
      repeat (L + 3) do_cycle();

      // Combined read+write from one user in a single access.
      set_req(2, 1'b1, 1'b1, 9, $urandom);
      do_cycle();
      clr_req(2);
      repeat (L + 3) do_cycle();

      // Users 0 and 2 request continuously.
      set_req(0, 1'b1, 1'b0, $urandom_range(0, 15), '0);
      set_req(2, 1'b1, 1'b0, $urandom_range(0, 15), '0);
      repeat (6) begin
         do_cycle();
         if (acc_user >= 0) set_req(acc_user, 1'b1, 1'b0, $urandom_range(0, 15), '0);
      end
      clr_req(0);
      drain();

      // Reset two cycles after a read is accepted: the read must vanish.
      set_req(1, 1'b1, 1'b0, 7, '0);
      do_cycle();
      clr_req(1);
      do_cycle();
      set_req(0, 1'b0, 1'b1, 3, $urandom);
      rst = 1'b1;
      #1;
      check("arst_in_ready", 64'(in_ready), 64'(0));
      check("arst_out_en", 64'({out_rd_en, out_wr_en}), 64'(0));
      check("arst_out_addr", 64'(out_addr), 64'(0));
      check("arst_out_wr_data", 64'(out_wr_data), 64'(0));
      check("arst_in_rd_valid", 64'(in_rd_valid), 64'(0));
      for (int u = 0; u < N; u++)
         check($sformatf("arst_in_rd_data[%0d]", u), 64'(in_rd_data[u]), 64'(0));
      clr_req(0);
      model_reset();
      #2;
      rst = 1'b0;
      repeat (L + 4) do_cycle();

      // Random traffic from any mix of users.
      repeat (300) begin
         do_cycle();
         if (acc_user >= 0) clr_req(acc_user);
         for (int u = 0; u < N; u++) begin
            if (!(in_rd_en[u] | in_wr_en[u]) && $urandom_range(0, 1) == 1) begin
               case ($urandom_range(0, 2))
                  0:       set_req(u, 1'b1, 1'b0, $urandom_range(0, 15), $urandom);
                  1:       set_req(u, 1'b0, 1'b1, $urandom_range(0, 15), $urandom);
                  default: set_req(u, 1'b1, 1'b1, $urandom_range(0, 15), $urandom);
               endcase
            end
         end
      end
      drain();
      check("resp_queue_empty", 64'(m_resp.size()), 64'(0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
